// File: rtl/comma_align_pkg.sv
// Shared constants, state encoding and the comma-pattern test for the
// word aligner and anything that needs to generate or recognise K28.5.
package comma_align_pkg;

   localparam logic [6:0] COMMA_P  = 7'b0011111;
   localparam logic [6:0] COMMA_N  = 7'b1100000;
   localparam int         OFFSET_W = 4;
   localparam int         NUM_OFF  = 10;

   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP = 10'b1100000101;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Only the abcdeif prefix matters; 'ghj' differs between K28.1/5/7.
   function automatic logic is_comma(input logic [9:0] cg);
      return (cg[9:3] == COMMA_P) || (cg[9:3] == COMMA_N);
   endfunction

endpackage

// File: rtl/comma_align_detect.sv
// Combinational comma search over all ten bit offsets of the 20-bit window;
// reports every hit plus the lowest hitting offset.
module comma_detect
   import comma_align_pkg::*;
(
   input  logic [19:0]         window,
   output logic [9:0]          hit,
   output logic                any_hit,
   output logic [OFFSET_W-1:0] first_hit
);

   always_comb begin
      hit       = '0;
      any_hit   = 1'b0;
      first_hit = '0;
      for (int k = 0; k < NUM_OFF; k++) begin
         hit[k] = is_comma(window[19-k -: 10]);
      end
      // Scan downwards so the lowest offset is the last one written.
      for (int k = NUM_OFF - 1; k >= 0; k--) begin
         if (hit[k]) begin
            any_hit   = 1'b1;
            first_hit = OFFSET_W'(k);
         end
      end
   end

endmodule

// File: rtl/comma_align.sv
// Word aligner in front of the 8B/10B decoder: finds the comma offset,
// confirms it over several commas, and streams aligned code groups.
module comma_align
   import comma_align_pkg::*;
#(
   parameter int CONFIRM_CNT = 4,
   parameter int LOSS_CNT    = 4
) (
   input  logic                BYTECLK,
   input  logic                reset,
   input  logic [9:0]          raw_in,
   output logic [9:0]          out,
   output logic                comma_det,
   output logic                locked,
   output logic [OFFSET_W-1:0] offset,
   output logic                realign
);

   localparam int CNT_W  = $clog2(CONFIRM_CNT + 1);
   localparam int LOSS_W = $clog2(LOSS_CNT + 1);

   logic [9:0]          r0;
   logic [9:0]          r1;
   logic [19:0]         window;
   logic [9:0]          hit;
   logic                any_hit;
   logic [OFFSET_W-1:0] first_hit;
   state_t              state;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_d;
   logic [LOSS_W-1:0]   loss_cnt;
   logic [LOSS_W-1:0]   loss_d;
   logic [OFFSET_W-1:0] offset_d;
   logic                realign_d;
   logic                own_hit;
   logic [9:0]          cand;

   assign window = {r1, r0};

   comma_detect u_detect (
      .window    (window),
      .hit       (hit),
      .any_hit   (any_hit),
      .first_hit (first_hit)
   );

   // Output mux and comma test at the currently latched offset.
   always_comb begin
      own_hit = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_OFF; k++) begin
         if (offset == OFFSET_W'(k)) begin
            own_hit = hit[k];
            cand    = window[19-k -: 10];
         end
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      loss_d    = loss_cnt;
      offset_d  = offset;
      realign_d = 1'b0;
      case (state)
         ST_HUNT: begin
            if (any_hit) begin
               offset_d  = first_hit;
               realign_d = 1'b1;
               cnt_d     = CNT_W'(1);
               state_d   = ST_VERIFY;
            end
         end
         ST_VERIFY: begin
            if (own_hit) begin
               cnt_d = cnt + 1'b1;
               if (cnt_d == CNT_W'(CONFIRM_CNT)) begin
                  state_d = ST_LOCKED;
                  loss_d  = '0;
               end
            end else if (any_hit) begin
               offset_d  = first_hit;
               realign_d = 1'b1;
               cnt_d     = CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (own_hit) begin
               loss_d = '0;
            end else if (any_hit) begin
               loss_d = loss_cnt + 1'b1;
               if (loss_d == LOSS_W'(LOSS_CNT)) begin
                  state_d = ST_HUNT;
                  cnt_d   = '0;
                  loss_d  = '0;
               end
            end
         end
         default: state_d = ST_HUNT;
      endcase
   end

   always_ff @(posedge BYTECLK) begin
      if (reset) begin
         r0        <= '0;
         r1        <= '0;
         out       <= '0;
         comma_det <= 1'b0;
         locked    <= 1'b0;
         offset    <= '0;
         realign   <= 1'b0;
         state     <= ST_HUNT;
         cnt       <= '0;
         loss_cnt  <= '0;
      end else begin
         r0        <= raw_in;
         r1        <= r0;
         out       <= cand;
         comma_det <= own_hit;
         locked    <= (state_d == ST_LOCKED);
         offset    <= offset_d;
         realign   <= realign_d;
         state     <= state_d;
         cnt       <= cnt_d;
         loss_cnt  <= loss_d;
      end
   end

endmodule

// File: tb/tb_comma_align.sv
// Self-checking bench for comma_align: serial bit-stream generator with slips
// and rotations, plus a bit-level reference model of the aligner.
module tb_comma_align;
   import comma_align_pkg::*;

   localparam logic [9:0] D21_5 = 10'b1010101010;
   localparam logic [9:0] D10_2 = 10'b0101010101;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] raw_in = '0;
   logic [9:0] out;
   logic       comma_det;
   logic       locked;
   logic [3:0] offset;
   logic       realign;

   always #5 clk = ~clk;

   comma_align dut (
      .BYTECLK   (clk),
      .reset     (reset),
      .raw_in    (raw_in),
      .out       (out),
      .comma_det (comma_det),
      .locked    (locked),
      .offset    (offset),
      .realign   (realign)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic tx_q[$];          // bits still to send, earliest on the wire first
   logic win_q[$];         // model's last 20 received bits, oldest first
   logic [9:0] sent_q[$];  // words sent since the last reset
   logic rd_neg = 1'b1;

   int m_st;               // 0 hunting, 1 verifying, 2 locked
   int m_off, m_cnt, m_loss;
   logic [9:0] e_out;
   logic e_det, e_locked, e_realign;

   logic chk_delay = 1'b0;
   logic chk_k = 1'b0;
   int realign_obs = 0;
   int det_obs = 0;
   int lock_obs = 0;

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] win_cand(input int k);
      logic [9:0] c;
      for (int i = 0; i < 10; i++) c[9-i] = win_q[k+i];
      return c;
   endfunction

   function automatic logic comma_at(input int k);
      logic [9:0] c;
      c = win_cand(k);
      return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
   endfunction

   task automatic model_edge(input logic [9:0] w);
      int lo;
      logic own;
      lo = -1;
      for (int k = 0; k < 10; k++) if (lo < 0 && comma_at(k)) lo = k;
      own       = comma_at(m_off);
      e_out     = win_cand(m_off);
      e_det     = own;
      e_realign = 1'b0;
      if (m_st == 0) begin
         if (lo >= 0) begin
            m_off = lo; e_realign = 1'b1; m_cnt = 1; m_st = 1;
         end
      end else if (m_st == 1) begin
         if (own) begin
            m_cnt++;
            if (m_cnt == 4) begin m_st = 2; m_loss = 0; end
         end else if (lo >= 0) begin
            m_off = lo; e_realign = 1'b1; m_cnt = 1;
         end
      end else begin
         if (own) m_loss = 0;
         else if (lo >= 0) begin
            m_loss++;
            if (m_loss == 4) begin m_st = 0; m_cnt = 0; m_loss = 0; end
         end
      end
      e_locked = (m_st == 2);
      for (int i = 9; i >= 0; i--) win_q.push_back(w[i]);
      repeat (10) win_q.delete(0);
   endtask

   task automatic compare_all();
      check("out", out, e_out);
      check("comma_det", 10'(comma_det), 10'(e_det));
      check("locked", 10'(locked), 10'(e_locked));
      check("offset", 10'(offset), 10'(m_off));
      check("realign", 10'(realign), 10'(e_realign));
   endtask

   task automatic step(input logic [9:0] w);
      raw_in = w;
      @(posedge clk);
      model_edge(w);
      sent_q.push_back(w);
      #1;
      compare_all();
      if (realign) realign_obs++;
      if (comma_det) det_obs++;
      if (locked) lock_obs++;
      if (chk_delay && sent_q.size() >= 3)
         check("delay2", out, sent_q[sent_q.size()-3]);
      if (chk_k && comma_det)
         check("k285", 10'((out == 10'b0011111010) || (out == 10'b1100000101)), 10'd1);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      raw_in = 10'($urandom_range(0, 1023));
      @(posedge clk);
      m_st = 0; m_off = 0; m_cnt = 0; m_loss = 0;
      e_out = '0; e_det = 1'b0; e_locked = 1'b0; e_realign = 1'b0;
      win_q.delete();
      repeat (20) win_q.push_back(1'b0);
      sent_q.delete();
      #1;
      compare_all();
      reset = 1'b0;
   endtask

   task automatic push_sym(input logic [9:0] s);
      for (int i = 9; i >= 0; i--) tx_q.push_back(s[i]);
   endtask

   task automatic push_fill();
      push_sym(($urandom_range(0, 1) == 1) ? D21_5 : D10_2);
   endtask

   // Each group: one K28.5 of running disparity, then 1..3 data fillers.
   task automatic k_groups(input int n);
      repeat (n) begin
         push_sym(rd_neg ? K28_5_RDN : K28_5_RDP);
         rd_neg = ~rd_neg;
         repeat ($urandom_range(1, 3)) push_fill();
      end
   endtask

   // Bit slip between two D21.5 symbols; inserted/removed bits keep runs short.
   task automatic slip(input int d);
      push_sym(D21_5);
      if (d == 1) tx_q.push_back(1'b1);
      else if (d == 2) begin tx_q.push_back(1'b1); tx_q.push_back(1'b0); end
      else tx_q.delete(tx_q.size() - 1);
      push_sym(D21_5);
   endtask

   // Restart the stream so symbols begin at word bit (10-p)%10.
   task automatic rotate(input int p);
      tx_q.delete();
      push_sym(D21_5);
      push_sym(D21_5);
      repeat (p) tx_q.delete(0);
   endtask

   task automatic send_all();
      logic [9:0] w;
      while (tx_q.size() >= 10) begin
         for (int i = 9; i >= 0; i--) begin
            w[i] = tx_q[0];
            tx_q.delete(0);
         end
         step(w);
      end
   endtask

   task automatic pad();
      push_sym(D21_5);
      push_sym(D21_5);
      send_all();
   endtask

   initial begin
      int p;
      int exp_off;

      // Reset state
      do_reset();
      check("rst_out", out, 10'd0);
      check("rst_locked", 10'(locked), 10'd0);
      check("rst_offset", 10'(offset), 10'd0);

      // Aligned stream
      tx_q.delete();
      realign_obs = 0;
      chk_delay = 1'b1;
      push_fill();
      k_groups(6);
      pad();
      chk_delay = 1'b0;
      check("p1_locked", 10'(locked), 10'd1);
      check("p1_offset", 10'(offset), 10'd0);
      check("p1_realigns", 10'(realign_obs), 10'd1);

      // Rotated by 3 bits
      do_reset();
      rotate(7);
      realign_obs = 0;
      chk_k = 1'b1;
      k_groups(6);
      pad();
      chk_k = 1'b0;
      check("p2_locked", 10'(locked), 10'd1);
      check("p2_offset", 10'(offset), 10'd3);
      check("p2_realigns", 10'(realign_obs), 10'd1);

      // Slip while locked: 3 foreign commas must not drop lock
      slip(1);
      k_groups(3);
      send_all();
      check("p3_hold_locked", 10'(locked), 10'd1);
      check("p3_hold_offset", 10'(offset), 10'd3);
      slip(-1);
      k_groups(2);
      slip(1);
      k_groups(4);
      send_all();
      check("p3_drop_locked", 10'(locked), 10'd0);
      check("p3_drop_offset", 10'(offset), 10'd3);
      k_groups(4);
      pad();
      check("p3_relock", 10'(locked), 10'd1);
      check("p3_new_offset", 10'(offset), 10'd4);

      // VERIFY interrupted by a comma at another offset
      do_reset();
      rotate(5);
      k_groups(2);
      send_all();
      check("p4_verify_locked", 10'(locked), 10'd0);
      check("p4_verify_offset", 10'(offset), 10'd5);
      slip(2);
      k_groups(3);
      send_all();
      check("p4_restart_locked", 10'(locked), 10'd0);
      check("p4_restart_offset", 10'(offset), 10'd7);
      k_groups(1);
      pad();
      check("p4_locked", 10'(locked), 10'd1);
      check("p4_offset", 10'(offset), 10'd7);

      // Comma-free data only
      do_reset();
      tx_q.delete();
      det_obs = 0;
      lock_obs = 0;
      repeat (30) push_fill();
      send_all();
      check("p5_no_det", 10'(det_obs), 10'd0);
      check("p5_no_lock", 10'(lock_obs), 10'd0);

      // Random rotation, then reset while locked
      p = $urandom_range(0, 9);
      exp_off = (10 - p) % 10;
      rotate(p);
      k_groups(6);
      pad();
      check("p6_locked", 10'(locked), 10'd1);
      check("p6_offset", 10'(offset), 10'(exp_off));
      do_reset();
      check("p6_rst_out", out, 10'd0);
      check("p6_rst_locked", 10'(locked), 10'd0);
      check("p6_rst_offset", 10'(offset), 10'd0);
      k_groups(6);
      pad();
      check("p6_relock", 10'(locked), 10'd1);
      check("p6_reoffset", 10'(offset), 10'(exp_off));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
